ps2_host_tx: RTL

- Host-to-device PS/2 transmitter; the companion to the existing PS/2 keyboard receiver.
- Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the device and checks the device ACK.
- Drives the shared open-drain PS/2 clock/data lines through drive-low enables; the top level converts these to tri-state pins.
- Asserts an inhibit flag so the receiver ignores line activity during a transmission.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_RTS_CYCLES     = 50;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  // Parity bit that makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Idle lines float high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with device ACK check.
// Optional watchdog from clock release to ACK: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txStart,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow,
  output logic       busy,
  output logic       rxInhibit,
  output logic       txDone,
  output logic       txErr
);

  localparam int PH_MAX0 = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PH_MAX  = (PH_MAX0 > TIMEOUT_CYCLES) ? PH_MAX0 : TIMEOUT_CYCLES;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  typedef logic [PH_W-1:0] phase_t;

  ps2_state_e  state_q, state_d;
  phase_t      phase_q, phase_d, phase_inc;
  logic [3:0]  edge_q, edge_d;
  logic [9:0]  frame_q, frame_d;
  logic        dl_q, dl_d;
  logic        ack_ok_q, ack_ok_d;
  logic        hi_q, hi_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2ClkIn),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2DataIn),
    .level_o(dat_lvl),
    .fall_o (dat_fall_unused)
  );

  assign phase_inc = (phase_q == {PH_W{1'b1}}) ? phase_q : phase_q + phase_t'(1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    edge_d   = edge_q;
    frame_d  = frame_q;
    dl_d     = dl_q;
    ack_ok_d = ack_ok_q;
    hi_d     = hi_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (txStart) begin
          frame_d = {1'b1, odd_parity(txData), txData};
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        phase_d = phase_inc;
        if (phase_q == phase_t'(INHIBIT_CYCLES - 1)) begin
          phase_d = '0;
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        phase_d = phase_inc;
        if (phase_q == phase_t'(RTS_CYCLES - 1)) begin
          phase_d = '0;
          state_d = ST_SHIFT;
          dl_d    = 1'b1;
          edge_d  = 4'd0;
          // An edge landing on the release cycle belongs to SHIFT.
          if (clk_fall) begin
            dl_d   = ~frame_q[0];
            edge_d = 4'd1;
          end
        end
      end
      ST_SHIFT: begin
        phase_d = phase_inc;
        if (clk_fall) begin
          dl_d   = ~frame_q[edge_q];
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        phase_d = phase_inc;
        if (clk_fall) begin
          ack_ok_d = ~dat_lvl;
          hi_d     = 1'b0;
          state_d  = ST_WAITIDLE;
        end
      end
      ST_WAITIDLE: begin
        if (clk_lvl && dat_lvl) begin
          if (hi_q) begin
            state_d = ST_IDLE;
            done_d  = ack_ok_q;
            err_d   = ~ack_ok_q;
          end else begin
            hi_d = 1'b1;
          end
        end else begin
          hi_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Phase counter restarts at clock release, so it doubles as the watchdog.
    if ((state_q == ST_SHIFT || state_q == ST_ACK) &&
        phase_q == phase_t'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      dl_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      edge_q   <= 4'd0;
      dl_q     <= 1'b0;
      ack_ok_q <= 1'b0;
      hi_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      edge_q   <= edge_d;
      dl_q     <= dl_d;
      ack_ok_q <= ack_ok_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign ps2ClkDriveLow  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
  assign ps2DataDriveLow = (state_q == ST_RTS) || ((state_q == ST_SHIFT) && dl_q);
  assign busy            = (state_q != ST_IDLE);
  assign rxInhibit       = busy;
  assign txDone          = done_q;
  assign txErr           = err_q;

endmodule
